clint_tmr_sched: RTL and testbench

- Multiplexes N_CH independent one-shot timer channels onto the single CLINT mtimecmp comparator.
- Keeps a deadline table and acts as a bus master on the CLINT timer register port.
- Programs mtimecmp with the earliest armed deadline. On irq_timer, snapshots mtime and retires every expired channel.
- Sits between software/DMA timer clients and the CLINT timer in the CHERIoT subsystem.

---
 rtl/clint_tmr_sched_pkg.sv | 38 +++
 rtl/clint_tmr_min_tree.sv | 29 ++
 rtl/clint_tmr_sched.sv | 217 +++++++++++++++++++++
 tb/tb_clint_tmr_sched.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_tmr_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : clint_tmr_sched_pkg
//  Description : Shared types and constants for the CLINT timer scheduler:
//                FSM state encoding, CLINT word offsets, disabled compare value.
//  Revision    : 1.0 - initial release
// ============================================================================
package clint_tmr_sched_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_LO_MAX = 4'd1,
        ST_WR_HI     = 4'd2,
        ST_WR_LO     = 4'd3,
        ST_SETTLE    = 4'd4,
        ST_RD_HI0    = 4'd5,
        ST_RD_LO     = 4'd6,
        ST_RD_HI1    = 4'd7,
        ST_EXPIRE    = 4'd8
    } state_e;

    // Word offsets inside the CLINT timer window
    localparam logic [29:0] MTIME_LO    = 30'd4;
    localparam logic [29:0] MTIME_HI    = 30'd5;
    localparam logic [29:0] MTIMECMP_LO = 30'd6;
    localparam logic [29:0] MTIMECMP_HI = 30'd7;

    // Compare value that can never fire; also the "nothing armed" target
    localparam logic [63:0] CMP_DISABLED = 64'hFFFF_FFFF_FFFF_FFFF;

    // Byte address of a CLINT register given its word offset
    function automatic logic [31:0] clint_addr(input logic [31:0] base,
                                               input logic [29:0] word_idx);
        return base + {word_idx, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/clint_tmr_min_tree.sv
`default_nettype none
// ============================================================================
//  Module      : clint_tmr_min_tree
//  Description : Combinational minimum over the armed entries of the deadline
//                table. Returns CMP_DISABLED when nothing is armed.
//  Revision    : 1.0 - initial release
// ============================================================================
module clint_tmr_min_tree
    import clint_tmr_sched_pkg::*;
#(
    parameter int N_CH = 4
) (
    input  logic [N_CH-1:0]       armed_i,
    input  logic [N_CH-1:0][63:0] deadline_i,
    output logic [63:0]           min_o
);

    // Ordered fold; the strict compare keeps the lowest index on equal values
    always_comb begin
        min_o = CMP_DISABLED;
        for (int i = 0; i < N_CH; i++) begin
            if (armed_i[i] && (deadline_i[i] < min_o)) begin
                min_o = deadline_i[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/clint_tmr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : clint_tmr_sched
//  Description : Multiplexes N_CH one-shot timer channels onto the single CLINT
//                mtimecmp comparator. Programs the earliest armed deadline and,
//                on the timer interrupt, snapshots mtime and retires every
//                expired channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module clint_tmr_sched
    import clint_tmr_sched_pkg::*;
#(
    parameter int          N_CH       = 4,
    parameter logic [31:0] CLINT_BASE = 32'h0,
    localparam int         CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            arm_valid_i,
    output logic            arm_ready_o,
    input  logic [CH_W-1:0] arm_ch_i,
    input  logic [63:0]     arm_deadline_i,
    input  logic [N_CH-1:0] cancel_i,
    output logic [N_CH-1:0] expired_o,
    output logic [N_CH-1:0] armed_o,
    output logic            busy_o,
    output logic            reg_en_o,
    output logic            reg_we_o,
    output logic [31:0]     reg_addr_o,
    output logic [31:0]     reg_wdata_o,
    input  logic [31:0]     reg_rdata_i,
    input  logic            reg_ready_i,
    input  logic            irq_timer_i
);

    state_e                state_q, state_d;
    logic [N_CH-1:0][63:0] deadline_q, deadline_d;
    logic [N_CH-1:0]       armed_q, armed_d;
    logic                  dirty_q, dirty_d;
    logic [63:0]           prog_cmp_q, prog_cmp_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [31:0]           hi0_q, hi0_d;
    logic [31:0]           lo_q, lo_d;
    logic [63:0]           snap_q, snap_d;
    logic                  arm_ready_q, arm_ready_d;

    logic [63:0]           w_target;
    logic [N_CH-1:0]       w_expire;
    logic                  w_arm_fire;

    clint_tmr_min_tree #(
        .N_CH       (N_CH)
    ) u_min_tree (
        .armed_i    (armed_q),
        .deadline_i (deadline_q),
        .min_o      (w_target)
    );

    // Channels whose deadline lies strictly before the mtime snapshot
    for (genvar i = 0; i < N_CH; i++) begin : g_expire
        assign w_expire[i] = armed_q[i] && (deadline_q[i] < snap_q);
    end

    assign arm_ready_o = arm_ready_q;
    assign armed_o     = armed_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign w_arm_fire  = arm_valid_i && arm_ready_q;

    // Next-state, table update and CLINT bus outputs
    always_comb begin
        state_d     = state_q;
        deadline_d  = deadline_q;
        armed_d     = armed_q;
        dirty_d     = dirty_q;
        prog_cmp_d  = prog_cmp_q;
        rd_pend_d   = rd_pend_q;
        hi0_d       = hi0_q;
        lo_d        = lo_q;
        snap_d      = snap_q;
        reg_en_o    = 1'b0;
        reg_we_o    = 1'b0;
        reg_addr_o  = 32'h0;
        reg_wdata_o = 32'h0;
        expired_o   = '0;

        case (state_q)
            ST_IDLE: begin
                // A pending reprogram is served first: right after EXPIRE the
                // interrupt is still high against the stale compare value, and
                // servicing it again would never let the new target go out.
                if (irq_timer_i && !dirty_q) begin
                    rd_pend_d = 1'b0;
                    state_d   = ST_RD_HI0;
                end else if (dirty_q) begin
                    prog_cmp_d = w_target;
                    dirty_d    = 1'b0;
                    state_d    = ST_WR_LO_MAX;
                end
            end
            // Parking lo at all-ones first avoids a transient early match
            ST_WR_LO_MAX: begin
                reg_en_o    = 1'b1;
                reg_we_o    = 1'b1;
                reg_addr_o  = clint_addr(CLINT_BASE, MTIMECMP_LO);
                reg_wdata_o = 32'hFFFF_FFFF;
                if (reg_ready_i) state_d = ST_WR_HI;
            end
            ST_WR_HI: begin
                reg_en_o    = 1'b1;
                reg_we_o    = 1'b1;
                reg_addr_o  = clint_addr(CLINT_BASE, MTIMECMP_HI);
                reg_wdata_o = prog_cmp_q[63:32];
                if (reg_ready_i) state_d = ST_WR_LO;
            end
            ST_WR_LO: begin
                reg_en_o    = 1'b1;
                reg_we_o    = 1'b1;
                reg_addr_o  = clint_addr(CLINT_BASE, MTIMECMP_LO);
                reg_wdata_o = prog_cmp_q[31:0];
                if (reg_ready_i) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = ST_IDLE;
            end
            ST_RD_HI0: begin
                if (rd_pend_q) begin
                    hi0_d     = reg_rdata_i;
                    rd_pend_d = 1'b0;
                    state_d   = ST_RD_LO;
                end else begin
                    reg_en_o   = 1'b1;
                    reg_addr_o = clint_addr(CLINT_BASE, MTIME_HI);
                    if (reg_ready_i) rd_pend_d = 1'b1;
                end
            end
            ST_RD_LO: begin
                if (rd_pend_q) begin
                    lo_d      = reg_rdata_i;
                    rd_pend_d = 1'b0;
                    state_d   = ST_RD_HI1;
                end else begin
                    reg_en_o   = 1'b1;
                    reg_addr_o = clint_addr(CLINT_BASE, MTIME_LO);
                    if (reg_ready_i) rd_pend_d = 1'b1;
                end
            end
            ST_RD_HI1: begin
                if (rd_pend_q) begin
                    rd_pend_d = 1'b0;
                    // hi moved under us: lo may belong to either epoch
                    if (reg_rdata_i != hi0_q) begin
                        state_d = ST_RD_HI0;
                    end else begin
                        snap_d  = {reg_rdata_i, lo_q};
                        state_d = ST_EXPIRE;
                    end
                end else begin
                    reg_en_o   = 1'b1;
                    reg_addr_o = clint_addr(CLINT_BASE, MTIME_HI);
                    if (reg_ready_i) rd_pend_d = 1'b1;
                end
            end
            ST_EXPIRE: begin
                expired_o = w_expire;
                armed_d   = armed_q & ~w_expire;
                dirty_d   = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Client updates land after the FSM so they override its dirty clear
        if (|cancel_i) begin
            armed_d = armed_d & ~cancel_i;
            dirty_d = 1'b1;
        end
        if (w_arm_fire) begin
            armed_d[arm_ch_i]    = 1'b1;
            deadline_d[arm_ch_i] = arm_deadline_i;
            dirty_d              = 1'b1;
        end
    end

    // Arms are refused for the single EXPIRE cycle so retirement sees a stable table
    assign arm_ready_d = (state_d != ST_EXPIRE);

    // State and table registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            deadline_q  <= {N_CH{CMP_DISABLED}};
            armed_q     <= '0;
            dirty_q     <= 1'b1;
            prog_cmp_q  <= CMP_DISABLED;
            rd_pend_q   <= 1'b0;
            hi0_q       <= 32'h0;
            lo_q        <= 32'h0;
            snap_q      <= 64'h0;
            arm_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            deadline_q  <= deadline_d;
            armed_q     <= armed_d;
            dirty_q     <= dirty_d;
            prog_cmp_q  <= prog_cmp_d;
            rd_pend_q   <= rd_pend_d;
            hi0_q       <= hi0_d;
            lo_q        <= lo_d;
            snap_q      <= snap_d;
            arm_ready_q <= arm_ready_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clint_tmr_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_clint_tmr_sched
//  Description : Directed self-checking bench for clint_tmr_sched with a small
//                behavioural CLINT timer (mtime, mtimecmp, level interrupt).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clint_tmr_sched;

    localparam int          N_CH  = 4;
    localparam logic [31:0] BASE  = 32'h0200_0000;
    localparam logic [31:0] A_MLO = 32'h0200_0010;
    localparam logic [31:0] A_MHI = 32'h0200_0014;
    localparam logic [31:0] A_CLO = 32'h0200_0018;
    localparam logic [31:0] A_CHI = 32'h0200_001C;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic            clk = 1'b0;
    logic            rstn;
    logic            arm_valid;
    logic            arm_ready;
    logic [1:0]      arm_ch;
    logic [63:0]     arm_dl;
    logic [N_CH-1:0] cancel;
    logic [N_CH-1:0] expired;
    logic [N_CH-1:0] armed;
    logic            busy;
    logic            reg_en, reg_we;
    logic [31:0]     reg_addr, reg_wdata;
    logic [31:0]     rdata_m = 32'h0;
    logic            reg_ready;
    logic            irq;

    // CLINT model state
    logic [63:0] bench_mtime;
    logic [63:0] mtimecmp_m = 64'h0;
    logic        tear_en;
    logic        tear_done = 1'b0;
    logic [63:0] mtime_eff;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] wr_log_addr [256];
    logic [31:0] wr_log_data [256];

    // Expiry monitor state
    int exp_pulses = 0;
    int exp_ch_cnt [N_CH];
    int snap_pulses;
    int snap_ch [N_CH];

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign mtime_eff = tear_done ? (bench_mtime + 64'd1) : bench_mtime;
    assign irq       = (mtime_eff > mtimecmp_m);

    clint_tmr_sched #(
        .N_CH           (N_CH),
        .CLINT_BASE     (BASE)
    ) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .arm_valid_i    (arm_valid),
        .arm_ready_o    (arm_ready),
        .arm_ch_i       (arm_ch),
        .arm_deadline_i (arm_dl),
        .cancel_i       (cancel),
        .expired_o      (expired),
        .armed_o        (armed),
        .busy_o         (busy),
        .reg_en_o       (reg_en),
        .reg_we_o       (reg_we),
        .reg_addr_o     (reg_addr),
        .reg_wdata_o    (reg_wdata),
        .reg_rdata_i    (rdata_m),
        .reg_ready_i    (reg_ready),
        .irq_timer_i    (irq)
    );

    // CLINT register port: writes update mtimecmp, reads return mtime next cycle
    always @(posedge clk) begin
        if (reg_en && reg_ready) begin
            if (reg_we) begin
                if (reg_addr == A_CLO) mtimecmp_m[31:0]  <= reg_wdata;
                if (reg_addr == A_CHI) mtimecmp_m[63:32] <= reg_wdata;
                wr_log_addr[wr_cnt % 256] <= reg_addr;
                wr_log_data[wr_cnt % 256] <= reg_wdata;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_cnt <= rd_cnt + 1;
                if (reg_addr == A_MLO) begin
                    rdata_m <= mtime_eff[31:0];
                    if (tear_en) tear_done <= 1'b1;
                end else if (reg_addr == A_MHI) begin
                    rdata_m <= mtime_eff[63:32];
                end else begin
                    rdata_m <= 32'h0;
                end
            end
        end
        if (!tear_en) tear_done <= 1'b0;
    end

    // Count expiry pulses per channel and in total
    always @(negedge clk) begin
        if (expired != '0) begin
            exp_pulses <= exp_pulses + 1;
            for (int i = 0; i < N_CH; i++) begin
                if (expired[i]) exp_ch_cnt[i] <= exp_ch_cnt[i] + 1;
            end
        end
    end

    initial begin
        for (int i = 0; i < N_CH; i++) exp_ch_cnt[i] = 0;
    end

    task automatic take_snap();
        snap_pulses = exp_pulses;
        for (int i = 0; i < N_CH; i++) snap_ch[i] = exp_ch_cnt[i];
    endtask

    function automatic logic [N_CH-1:0] obs_mask();
        logic [N_CH-1:0] m;
        m = '0;
        for (int i = 0; i < N_CH; i++) m[i] = (exp_ch_cnt[i] != snap_ch[i]);
        return m;
    endfunction

    // Wait until the scheduler has been idle for three consecutive cycles
    task automatic wait_idle(input string tag);
        int idle;
        idle = 0;
        for (int i = 0; i < 400 && idle < 3; i++) begin
            @(negedge clk);
            idle = busy ? 0 : idle + 1;
        end
        if (idle < 3) begin
            n_total++;
            $display("FAIL %s_idle_timeout: busy_o=%0b required 0 within 400 cycles", tag, busy);
        end
    endtask

    task automatic arm(input logic [1:0] ch, input logic [63:0] dl);
        bit took;
        int n;
        arm_valid = 1'b1;
        arm_ch    = ch;
        arm_dl    = dl;
        took      = 1'b0;
        n         = 0;
        while (!took && n < 50) begin
            took = arm_ready;
            @(negedge clk);
            n++;
        end
        arm_valid = 1'b0;
        if (!took) begin
            n_total++;
            $display("FAIL arm_accept_ch%0d: arm_ready_o=0 required 1", ch);
        end
    endtask

    task automatic test_reset();
        int w0;
        n_total++;
        if ({armed, expired, busy, reg_en, arm_ready} !== 11'h0)
            $display("FAIL reset_outputs: got %h required 0", {armed, expired, busy, reg_en, arm_ready});
        else n_pass++;
        w0 = wr_cnt;
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL reset_busy_4: busy_o=%0b required 1", busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy_5: busy_o=%0b required 0", busy);
        else n_pass++;
        n_total++;
        if (wr_cnt - w0 != 3) $display("FAIL reset_wr_count: got %0d required 3", wr_cnt - w0);
        else n_pass++;
        n_total++;
        if ({wr_log_addr[w0], wr_log_data[w0], wr_log_addr[w0+1], wr_log_data[w0+1],
             wr_log_addr[w0+2], wr_log_data[w0+2]} !==
            {A_CLO, 32'hFFFF_FFFF, A_CHI, 32'hFFFF_FFFF, A_CLO, 32'hFFFF_FFFF})
            $display("FAIL reset_wr_seq: got %h/%h %h/%h %h/%h", wr_log_addr[w0], wr_log_data[w0],
                     wr_log_addr[w0+1], wr_log_data[w0+1], wr_log_addr[w0+2], wr_log_data[w0+2]);
        else n_pass++;
        n_total++;
        if (arm_ready !== 1'b1) $display("FAIL reset_arm_ready: got %0b required 1", arm_ready);
        else n_pass++;
    endtask

    task automatic test_two_channels();
        bench_mtime = 64'h10;
        arm(2'd2, 64'h100);
        arm(2'd0, 64'h80);
        wait_idle("two_prog");
        n_total++;
        if (mtimecmp_m !== 64'h80) $display("FAIL two_cmp_first: got %h required 80", mtimecmp_m);
        else n_pass++;
        n_total++;
        if (armed !== 4'b0101) $display("FAIL two_armed: got %b required 0101", armed);
        else n_pass++;
        take_snap();
        bench_mtime = 64'h81;
        wait_idle("two_exp0");
        n_total++;
        if ({obs_mask(), 8'(exp_pulses - snap_pulses)} !== {4'b0001, 8'd1})
            $display("FAIL two_expire_ch0: mask %b pulses %0d required 0001 1", obs_mask(), exp_pulses - snap_pulses);
        else n_pass++;
        n_total++;
        if ({mtimecmp_m, armed} !== {64'h100, 4'b0100})
            $display("FAIL two_reprog: cmp %h armed %b required 100 0100", mtimecmp_m, armed);
        else n_pass++;
        take_snap();
        bench_mtime = 64'h101;
        wait_idle("two_exp2");
        n_total++;
        if ({obs_mask(), 8'(exp_pulses - snap_pulses)} !== {4'b0100, 8'd1})
            $display("FAIL two_expire_ch2: mask %b pulses %0d required 0100 1", obs_mask(), exp_pulses - snap_pulses);
        else n_pass++;
        n_total++;
        if ({mtimecmp_m, armed} !== {ONES, 4'b0000})
            $display("FAIL two_final: cmp %h armed %b required all-ones 0000", mtimecmp_m, armed);
        else n_pass++;
    endtask

    task automatic test_tie();
        arm(2'd1, 64'h200);
        arm(2'd3, 64'h200);
        wait_idle("tie_prog");
        n_total++;
        if (mtimecmp_m !== 64'h200) $display("FAIL tie_cmp: got %h required 200", mtimecmp_m);
        else n_pass++;
        take_snap();
        bench_mtime = 64'h201;
        wait_idle("tie_exp");
        n_total++;
        if ({obs_mask(), 8'(exp_pulses - snap_pulses)} !== {4'b1010, 8'd1})
            $display("FAIL tie_expire: mask %b pulses %0d required 1010 1", obs_mask(), exp_pulses - snap_pulses);
        else n_pass++;
    endtask

    task automatic test_cancel();
        arm(2'd1, 64'h300);
        wait_idle("cancel_prog");
        n_total++;
        if (mtimecmp_m !== 64'h300) $display("FAIL cancel_cmp_armed: got %h required 300", mtimecmp_m);
        else n_pass++;
        take_snap();
        bench_mtime = 64'h2F0;
        cancel = 4'b0010;
        @(negedge clk);
        cancel = 4'b0000;
        wait_idle("cancel_reprog");
        n_total++;
        if ({mtimecmp_m, armed} !== {ONES, 4'b0000})
            $display("FAIL cancel_reprog: cmp %h armed %b required all-ones 0000", mtimecmp_m, armed);
        else n_pass++;
        bench_mtime = 64'h310;
        wait_idle("cancel_pass");
        n_total++;
        if (exp_pulses != snap_pulses) $display("FAIL cancel_no_expiry: pulses %0d required 0", exp_pulses - snap_pulses);
        else n_pass++;
        // Same-cycle arm and cancel on channel 1: the arm takes effect
        arm_valid = 1'b1;
        arm_ch    = 2'd1;
        arm_dl    = 64'h400;
        cancel    = 4'b0010;
        @(negedge clk);
        arm_valid = 1'b0;
        cancel    = 4'b0000;
        n_total++;
        if (armed[1] !== 1'b1) $display("FAIL arm_beats_cancel: armed_o[1]=%0b required 1", armed[1]);
        else n_pass++;
        wait_idle("arm_cancel");
        n_total++;
        if (mtimecmp_m !== 64'h400) $display("FAIL arm_cancel_cmp: got %h required 400", mtimecmp_m);
        else n_pass++;
        cancel = 4'b0010;
        @(negedge clk);
        cancel = 4'b0000;
        wait_idle("cancel_clean");
    endtask

    task automatic test_torn_read();
        int r0;
        arm(2'd0, 64'h0000_0000_FFFF_FFF0);
        arm(2'd1, 64'h0000_0001_0000_0010);
        wait_idle("torn_prog");
        n_total++;
        if (mtimecmp_m !== 64'hFFFF_FFF0) $display("FAIL torn_cmp_before: got %h required ffff_fff0", mtimecmp_m);
        else n_pass++;
        take_snap();
        r0          = rd_cnt;
        tear_en     = 1'b1;
        bench_mtime = 64'h0000_0000_FFFF_FFFF;
        wait_idle("torn_exp");
        n_total++;
        if (rd_cnt - r0 != 6) $display("FAIL torn_read_count: got %0d required 6", rd_cnt - r0);
        else n_pass++;
        n_total++;
        if ({obs_mask(), armed} !== {4'b0001, 4'b0010})
            $display("FAIL torn_expire: mask %b armed %b required 0001 0010", obs_mask(), armed);
        else n_pass++;
        n_total++;
        if (mtimecmp_m !== 64'h0000_0001_0000_0010) $display("FAIL torn_reprog: got %h required 1_0000_0010", mtimecmp_m);
        else n_pass++;
        tear_en     = 1'b0;
        bench_mtime = 64'h0000_0001_0000_0000;
        cancel      = 4'b0010;
        @(negedge clk);
        cancel      = 4'b0000;
        wait_idle("torn_clean");
    endtask

    task automatic test_stall();
        int  w0;
        bit  found;
        arm(2'd3, 64'h0000_0005_0000_0123);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (reg_en && reg_we && reg_addr == A_CHI) found = 1'b1;
            else @(negedge clk);
        end
        n_total++;
        if (!found) $display("FAIL stall_reach_wr_hi: WR_HI access not observed, required within 20 cycles");
        else n_pass++;
        reg_ready = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({reg_en, reg_we, reg_addr, reg_wdata} !== {1'b1, 1'b1, A_CHI, 32'h5})
                $display("FAIL stall_hold_%0d: en %0b we %0b addr %h data %h required 1 1 %h 5",
                         i, reg_en, reg_we, reg_addr, reg_wdata, A_CHI);
            else n_pass++;
        end
        reg_ready = 1'b1;
        wait_idle("stall_done");
        n_total++;
        if ({32'(wr_cnt - w0), wr_log_addr[w0 % 256], wr_log_data[w0 % 256]} !== {32'd2, A_CHI, 32'h5})
            $display("FAIL stall_writes: count %0d first %h/%h required 2 %h/5",
                     wr_cnt - w0, wr_log_addr[w0 % 256], wr_log_data[w0 % 256], A_CHI);
        else n_pass++;
        n_total++;
        if (mtimecmp_m !== 64'h0000_0005_0000_0123) $display("FAIL stall_cmp: got %h required 5_0000_0123", mtimecmp_m);
        else n_pass++;
    endtask

    task automatic test_past_deadline();
        take_snap();
        arm(2'd2, 64'h50);
        wait_idle("past");
        n_total++;
        if ({obs_mask(), armed} !== {4'b0100, 4'b1000})
            $display("FAIL past_expire: mask %b armed %b required 0100 1000", obs_mask(), armed);
        else n_pass++;
        n_total++;
        if (mtimecmp_m !== 64'h0000_0005_0000_0123) $display("FAIL past_cmp: got %h required 5_0000_0123", mtimecmp_m);
        else n_pass++;
    endtask

    initial begin
        rstn        = 1'b0;
        arm_valid   = 1'b0;
        arm_ch      = 2'd0;
        arm_dl      = 64'h0;
        cancel      = '0;
        reg_ready   = 1'b1;
        bench_mtime = 64'h0;
        tear_en     = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_two_channels();
        test_tie();
        test_cancel();
        test_torn_read();
        test_stall();
        test_past_deadline();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
